ctrl_unit_mc: RTL and testbench
===============================

Name: ctrl_unit_mc

Overview:
- Parametrised multicycle control FSM for the MIPS-subset datapath; successor to the flat, unparametrised controller.
- Adds a configurable memory wait-state count and configurable mux-select widths.
- Adds a start/done handshake with the sequential mult/div unit, plus precise exceptions (overflow, invalid opcode, divide-by-zero) that save EPC and vector through memory.
- Sits beside the datapath top; drives every register write enable and mux select.

Parameters:
MEM_WAIT, 1, extra cycles a memory read needs before data is valid (0..7).
SEL_W, 3, width of every mux-select output.
STACK_INIT, 227, value written to $29 on reset.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset; one clock
overflow  in  1  ALU overflow, valid in EXEC cycles
zero  in  1  ALU zero, valid in BRANCH
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
md_done  in  1  mult/div finished; pulse
div_zero  in  1  divisor zero; valid with md_done
pc_w, mem_w, ir_w, a_w, b_w, alu_out_w, reg_w, epc_w, hilo_w  out  1 each  register and memory write enables
md_start  out  1  one-cycle start pulse to mult/div
md_op  out  1  0 = mult, 1 = div
alu_op  out  3  ALU function: ADD=001, SUB=010, AND=011
pc_src_s, mem_addr_s, reg_dst_s, wb_data_s, alu_a_s, alu_b_s  out  SEL_W each  mux selects; encodings in package
res_out  out  1  high in RST state only
state_dbg  out  5  current state code

Behaviour:
- All outputs are Moore, decoded from state and the wait counter.
- Every output is 0 unless listed for the current state.
- reset==0 at a clk edge forces state RST and counter 0, including mid-operation.
  - Any md_done arriving later is ignored until a new md_start.
- RST (1 cycle): res_out=1, reg_w=1, reg_dst_s=R29, wb_data_s=STACK. Next state FETCH.
- FETCH: mem_addr_s=PC; ALU computes PC+4 (alu_a_s=PC, alu_b_s=FOUR, ADD). State lasts MEM_WAIT+1 cycles, counted by cnt.
  - Final cycle only: ir_w=1, pc_w=1, pc_src_s=ALU.
- DECODE (1 cycle): a_w=b_w=1; alu_out_w=1 with target PC+(sext imm<<2).
- DECODE dispatch on opcode:
  - 0x00 with funct add/sub/and (0x20/0x22/0x24) -> EXEC_R.
  - 0x00 with funct 0x18/0x1A -> MD_START.
  - 0x08 -> EXEC_I.
  - 0x23/0x2B -> ADDR.
  - 0x04/0x05 -> BRANCH.
  - 0x02 -> JUMP.
  - Anything else, including other R-funct -> EXC_OPC.
- EXEC_R / EXEC_I (1 cycle): alu_out_w=1.
  - If overflow==1 and the op is add, sub or addi -> EXC_OVF. Register file is not written.
  - Otherwise -> WB (reg_w=1; reg_dst_s=RD or RT; wb_data_s=ALUOUT) -> FETCH.
- ADDR: alu_out_w=1, effective address.
  - lw -> LW_MEM: MEM_WAIT+1 cycles, mem_addr_s=ALUOUT -> LW_WB (reg_w=1, wb_data_s=MDR) -> FETCH.
  - sw -> SW_MEM: 1 cycle, mem_w=1 -> FETCH.
- BRANCH: ALU does A−B (SUB). pc_w = (zero XOR opcode==0x05), pc_src_s=ALUOUT. Next state FETCH.
- JUMP: pc_w=1, pc_src_s=JADDR. Next state FETCH.
- MD_START (1 cycle): md_start=1, md_op=funct[1]. Next state MD_WAIT.
- MD_WAIT: hold until md_done.
  - md_done with md_op=1 and div_zero -> EXC_DIV.
  - Otherwise -> MD_WB (hilo_w=1, 1 cycle) -> FETCH.
  - md_done in the same cycle as entering MD_WAIT is accepted.
- EXC_OVF / EXC_OPC / EXC_DIV (1 cycle): epc_w=1, EPC gets PC−4 (alu_a_s=PC, alu_b_s=FOUR, SUB). Exception code is latched. Next state EXC_LD.
- EXC_LD: MEM_WAIT+1 cycles, mem_addr_s = vector for the latched code (opcode 253, overflow 254, div 255).
  - Final cycle: pc_w=1, pc_src_s=MEMBYTE. Next state FETCH.
- cnt width is clog2(MEM_WAIT+1), min 1. cnt clears on every state change.
- MEM_WAIT=0 makes every memory state exactly 1 cycle.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (5-bit codes);
  - opcode and funct constants;
  - ALU op codes;
  - mux-select encodings for each mux (sized SEL_W);
  - exception vector addresses 253/254/255.
- One sub-module, ctrl_wait_cnt: loadable wait counter with a last_cycle flag, reused by FETCH, LW_MEM and EXC_LD.

Test Plan:
- reset=0 for 2 cycles, then release -> RST lasts 1 cycle with res_out=1, reg_w=1, wb_data_s=STACK; next state FETCH; all other enables 0.
- MEM_WAIT=2, add with no overflow -> ir_w on FETCH cycle 3; DECODE; EXEC_R; WB with reg_w=1, reg_dst_s=RD; total 6 cycles.
- add with overflow=1 in EXEC_R -> no reg_w; EXC_OVF epc_w=1 with SUB; EXC_LD mem_addr_s=vector 254; pc_w with MEMBYTE on the last cycle.
- div with md_done after 33 cycles and div_zero=1 -> md_start a single pulse, md_op=1; no hilo_w; exception vector 255.
- beq with zero=1, then bne with zero=1 -> pc_w=1 in BRANCH for beq; pc_w=0 for bne.
- opcode 0x3F -> EXC_OPC with vector 253.
- reset asserted mid-MD_WAIT -> RST on the next cycle; a following stray md_done is ignored.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, ISA fields,
// ALU functions, mux-select values and exception vector addresses.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST      = 5'd0,
    S_FETCH    = 5'd1,
    S_DECODE   = 5'd2,
    S_EXEC_R   = 5'd3,
    S_EXEC_I   = 5'd4,
    S_WB       = 5'd5,
    S_ADDR     = 5'd6,
    S_LW_MEM   = 5'd7,
    S_LW_WB    = 5'd8,
    S_SW_MEM   = 5'd9,
    S_BRANCH   = 5'd10,
    S_JUMP     = 5'd11,
    S_MD_START = 5'd12,
    S_MD_WAIT  = 5'd13,
    S_MD_WB    = 5'd14,
    S_EXC_OVF  = 5'd15,
    S_EXC_OPC  = 5'd16,
    S_EXC_DIV  = 5'd17,
    S_EXC_LD   = 5'd18
  } state_e;

  typedef enum logic [1:0] {
    ECODE_OPC = 2'd0,
    ECODE_OVF = 2'd1,
    ECODE_DIV = 2'd2
  } exc_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  // Select values are plain ints; users cast them to their SEL_W.
  localparam int PC_SRC_ALU       = 1;
  localparam int PC_SRC_ALUOUT    = 2;
  localparam int PC_SRC_JADDR     = 3;
  localparam int PC_SRC_MEMBYTE   = 4;

  localparam int MEM_ADDR_PC      = 1;
  localparam int MEM_ADDR_ALUOUT  = 2;
  localparam int MEM_ADDR_VEC_OPC = 3;
  localparam int MEM_ADDR_VEC_OVF = 4;
  localparam int MEM_ADDR_VEC_DIV = 5;

  localparam int REG_DST_RD       = 1;
  localparam int REG_DST_RT       = 2;
  localparam int REG_DST_R29      = 3;

  localparam int WB_ALUOUT        = 1;
  localparam int WB_MDR           = 2;
  localparam int WB_STACK         = 3;

  localparam int ALU_A_PC         = 1;
  localparam int ALU_A_A          = 2;

  localparam int ALU_B_B          = 1;
  localparam int ALU_B_FOUR       = 2;
  localparam int ALU_B_SEXT       = 3;
  localparam int ALU_B_SEXT_SH2   = 4;

  localparam logic [7:0] VEC_OPC  = 8'd253;
  localparam logic [7:0] VEC_OVF  = 8'd254;
  localparam logic [7:0] VEC_DIV  = 8'd255;

endpackage

// File: rtl/ctrl_unit_mc_if.sv
// Controller <-> datapath bundle: status/IR fields in, enables and selects out.
interface ctrl_unit_mc_if #(
  parameter int SEL_W = 3
);
  logic             overflow, zero, md_done, div_zero;
  logic [5:0]       opcode, funct;
  logic             pc_w, mem_w, ir_w, a_w, b_w, alu_out_w, reg_w, epc_w, hilo_w;
  logic             md_start, md_op;
  logic [2:0]       alu_op;
  logic [SEL_W-1:0] pc_src_s, mem_addr_s, reg_dst_s, wb_data_s, alu_a_s, alu_b_s;

  modport master (
    input  overflow, zero, md_done, div_zero, opcode, funct,
    output pc_w, mem_w, ir_w, a_w, b_w, alu_out_w, reg_w, epc_w, hilo_w,
           md_start, md_op, alu_op,
           pc_src_s, mem_addr_s, reg_dst_s, wb_data_s, alu_a_s, alu_b_s
  );

  modport slave (
    output overflow, zero, md_done, div_zero, opcode, funct,
    input  pc_w, mem_w, ir_w, a_w, b_w, alu_out_w, reg_w, epc_w, hilo_w,
           md_start, md_op, alu_op,
           pc_src_s, mem_addr_s, reg_dst_s, wb_data_s, alu_a_s, alu_b_s
  );
endinterface

// File: rtl/ctrl_wait_cnt.sv
// Memory wait-state counter: counts up to MAX while enabled, cleared on load.
module ctrl_wait_cnt #(
  parameter int MAX = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int CW = (MAX > 0) ? $clog2(MAX + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)              cnt_d = '0;
    else if (en && !last) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ctrl_unit_mc.sv
// Multicycle MIPS-subset control FSM with memory wait states, mult/div
// handshake and precise exceptions vectored through memory.
module ctrl_unit_mc
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT   = 1,
  parameter int SEL_W      = 3,
  parameter int STACK_INIT = 227
) (
  input  logic           clk,
  input  logic           reset,
  ctrl_unit_mc_if.master bus,
  output logic           res_out,
  output logic [4:0]     state_dbg
);
  if (MEM_WAIT < 0 || MEM_WAIT > 7 || SEL_W < 3 || STACK_INIT < 0) begin : g_param_check
    $error("ctrl_unit_mc: parameter out of range");
  end

  state_e state_q, state_d;
  exc_e   exc_q, exc_d;
  logic   last, cnt_en, cnt_clr;

  assign cnt_en    = (state_q == S_FETCH) || (state_q == S_LW_MEM) || (state_q == S_EXC_LD);
  assign cnt_clr   = (state_d != state_q);
  assign state_dbg = state_q;

  ctrl_wait_cnt #(.MAX(MEM_WAIT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RST;
      exc_q   <= ECODE_OPC;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    if (last) state_d = S_DECODE;
      S_DECODE: begin
        if (bus.opcode == OP_RTYPE &&
            (bus.funct == FN_ADD || bus.funct == FN_SUB || bus.funct == FN_AND))
          state_d = S_EXEC_R;
        else if (bus.opcode == OP_RTYPE && (bus.funct == FN_MULT || bus.funct == FN_DIV))
          state_d = S_MD_START;
        else if (bus.opcode == OP_ADDI)                         state_d = S_EXEC_I;
        else if (bus.opcode == OP_LW || bus.opcode == OP_SW)    state_d = S_ADDR;
        else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE)  state_d = S_BRANCH;
        else if (bus.opcode == OP_J)                            state_d = S_JUMP;
        else                                                    state_d = S_EXC_OPC;
      end
      // and never traps on overflow; add/sub/addi do
      S_EXEC_R:   state_d = (bus.overflow && bus.funct != FN_AND) ? S_EXC_OVF : S_WB;
      S_EXEC_I:   state_d = bus.overflow ? S_EXC_OVF : S_WB;
      S_ADDR:     state_d = (bus.opcode == OP_LW) ? S_LW_MEM : S_SW_MEM;
      S_LW_MEM:   if (last) state_d = S_LW_WB;
      S_MD_START: state_d = S_MD_WAIT;
      S_MD_WAIT: begin
        if (bus.md_done) state_d = (bus.funct[1] && bus.div_zero) ? S_EXC_DIV : S_MD_WB;
      end
      S_EXC_OVF:  begin state_d = S_EXC_LD; exc_d = ECODE_OVF; end
      S_EXC_OPC:  begin state_d = S_EXC_LD; exc_d = ECODE_OPC; end
      S_EXC_DIV:  begin state_d = S_EXC_LD; exc_d = ECODE_DIV; end
      S_EXC_LD:   if (last) state_d = S_FETCH;
      S_WB, S_LW_WB, S_SW_MEM, S_BRANCH, S_JUMP, S_MD_WB: state_d = S_FETCH;
      default:    state_d = S_RST;
    endcase
  end

  always_comb begin
    bus.pc_w = 1'b0;      bus.mem_w = 1'b0;  bus.ir_w = 1'b0;    bus.a_w = 1'b0;
    bus.b_w = 1'b0;       bus.alu_out_w = 1'b0; bus.reg_w = 1'b0; bus.epc_w = 1'b0;
    bus.hilo_w = 1'b0;    bus.md_start = 1'b0; bus.md_op = 1'b0;  bus.alu_op = '0;
    bus.pc_src_s = '0;    bus.mem_addr_s = '0; bus.reg_dst_s = '0; bus.wb_data_s = '0;
    bus.alu_a_s = '0;     bus.alu_b_s = '0;  res_out = 1'b0;
    case (state_q)
      S_RST: begin
        res_out = 1'b1; bus.reg_w = 1'b1;
        bus.reg_dst_s = SEL_W'(REG_DST_R29); bus.wb_data_s = SEL_W'(WB_STACK);
      end
      S_FETCH: begin
        bus.mem_addr_s = SEL_W'(MEM_ADDR_PC);
        bus.alu_a_s = SEL_W'(ALU_A_PC); bus.alu_b_s = SEL_W'(ALU_B_FOUR); bus.alu_op = ALU_ADD;
        if (last) begin
          bus.ir_w = 1'b1; bus.pc_w = 1'b1; bus.pc_src_s = SEL_W'(PC_SRC_ALU);
        end
      end
      S_DECODE: begin
        bus.a_w = 1'b1; bus.b_w = 1'b1; bus.alu_out_w = 1'b1;
        bus.alu_a_s = SEL_W'(ALU_A_PC); bus.alu_b_s = SEL_W'(ALU_B_SEXT_SH2); bus.alu_op = ALU_ADD;
      end
      S_EXEC_R: begin
        bus.alu_out_w = 1'b1;
        bus.alu_a_s = SEL_W'(ALU_A_A); bus.alu_b_s = SEL_W'(ALU_B_B);
        bus.alu_op = (bus.funct == FN_ADD) ? ALU_ADD : (bus.funct == FN_SUB) ? ALU_SUB : ALU_AND;
      end
      S_EXEC_I, S_ADDR: begin
        bus.alu_out_w = 1'b1;
        bus.alu_a_s = SEL_W'(ALU_A_A); bus.alu_b_s = SEL_W'(ALU_B_SEXT); bus.alu_op = ALU_ADD;
      end
      S_WB: begin
        bus.reg_w = 1'b1; bus.wb_data_s = SEL_W'(WB_ALUOUT);
        bus.reg_dst_s = (bus.opcode == OP_RTYPE) ? SEL_W'(REG_DST_RD) : SEL_W'(REG_DST_RT);
      end
      S_LW_MEM: bus.mem_addr_s = SEL_W'(MEM_ADDR_ALUOUT);
      S_LW_WB: begin
        bus.reg_w = 1'b1; bus.reg_dst_s = SEL_W'(REG_DST_RT); bus.wb_data_s = SEL_W'(WB_MDR);
      end
      S_SW_MEM: begin
        bus.mem_w = 1'b1; bus.mem_addr_s = SEL_W'(MEM_ADDR_ALUOUT);
      end
      S_BRANCH: begin
        bus.alu_a_s = SEL_W'(ALU_A_A); bus.alu_b_s = SEL_W'(ALU_B_B); bus.alu_op = ALU_SUB;
        bus.pc_w = bus.zero ^ (bus.opcode == OP_BNE);
        bus.pc_src_s = SEL_W'(PC_SRC_ALUOUT);
      end
      S_JUMP: begin
        bus.pc_w = 1'b1; bus.pc_src_s = SEL_W'(PC_SRC_JADDR);
      end
      S_MD_START: begin
        bus.md_start = 1'b1; bus.md_op = bus.funct[1];
      end
      S_MD_WB: bus.hilo_w = 1'b1;
      S_EXC_OVF, S_EXC_OPC, S_EXC_DIV: begin
        bus.epc_w = 1'b1;
        bus.alu_a_s = SEL_W'(ALU_A_PC); bus.alu_b_s = SEL_W'(ALU_B_FOUR); bus.alu_op = ALU_SUB;
      end
      S_EXC_LD: begin
        case (exc_q)
          ECODE_OVF: bus.mem_addr_s = SEL_W'(MEM_ADDR_VEC_OVF);
          ECODE_DIV: bus.mem_addr_s = SEL_W'(MEM_ADDR_VEC_DIV);
          default:   bus.mem_addr_s = SEL_W'(MEM_ADDR_VEC_OPC);
        endcase
        if (last) begin
          bus.pc_w = 1'b1; bus.pc_src_s = SEL_W'(PC_SRC_MEMBYTE);
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Scoreboard bench for ctrl_unit_mc: an instruction-level model queues the
// expected per-cycle outputs; a monitor compares them mid-cycle.
module tb_ctrl_unit_mc;
  import ctrl_pkg::*;

  localparam int MW = 2;
  localparam int W  = MW + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       res_out;
  logic [4:0] state_dbg;

  ctrl_unit_mc_if #(.SEL_W(3)) bus ();

  ctrl_unit_mc #(.MEM_WAIT(MW), .SEL_W(3), .STACK_INIT(227)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .res_out   (res_out),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_w, mem_w, ir_w, a_w, b_w, alu_out_w, reg_w, epc_w, hilo_w, md_start, md_op;
    logic [2:0] alu_op;
    logic [2:0] pc_src_s, mem_addr_s, reg_dst_s, wb_data_s, alu_a_s, alu_b_s;
    logic res_out;
  } out_t;

  out_t  act;
  out_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  assign act = {bus.pc_w, bus.mem_w, bus.ir_w, bus.a_w, bus.b_w, bus.alu_out_w, bus.reg_w,
                bus.epc_w, bus.hilo_w, bus.md_start, bus.md_op, bus.alu_op,
                bus.pc_src_s, bus.mem_addr_s, bus.reg_dst_s, bus.wb_data_s,
                bus.alu_a_s, bus.alu_b_s, res_out};

  function automatic logic [2:0] s(input int v); return 3'(v); endfunction
  function automatic logic rb(); return 1'($urandom_range(0, 1)); endfunction

  function automatic out_t v_rst();
    out_t v = '0;
    v.res_out = 1'b1; v.reg_w = 1'b1; v.reg_dst_s = s(REG_DST_R29); v.wb_data_s = s(WB_STACK);
    return v;
  endfunction
  function automatic out_t v_fetch(input bit fin);
    out_t v = '0;
    v.mem_addr_s = s(MEM_ADDR_PC); v.alu_a_s = s(ALU_A_PC); v.alu_b_s = s(ALU_B_FOUR);
    v.alu_op = 3'b001;
    if (fin) begin v.ir_w = 1'b1; v.pc_w = 1'b1; v.pc_src_s = s(PC_SRC_ALU); end
    return v;
  endfunction
  function automatic out_t v_decode();
    out_t v = '0;
    v.a_w = 1'b1; v.b_w = 1'b1; v.alu_out_w = 1'b1;
    v.alu_a_s = s(ALU_A_PC); v.alu_b_s = s(ALU_B_SEXT_SH2); v.alu_op = 3'b001;
    return v;
  endfunction
  function automatic out_t v_calc(input int b, input logic [2:0] op);
    out_t v = '0;
    v.alu_out_w = 1'b1; v.alu_a_s = s(ALU_A_A); v.alu_b_s = s(b); v.alu_op = op;
    return v;
  endfunction
  function automatic out_t v_wb(input int dst, input int src);
    out_t v = '0;
    v.reg_w = 1'b1; v.reg_dst_s = s(dst); v.wb_data_s = s(src);
    return v;
  endfunction
  function automatic out_t v_mem(input bit wr);
    out_t v = '0;
    v.mem_w = wr; v.mem_addr_s = s(MEM_ADDR_ALUOUT);
    return v;
  endfunction
  function automatic out_t v_branch(input logic take);
    out_t v = '0;
    v.alu_a_s = s(ALU_A_A); v.alu_b_s = s(ALU_B_B); v.alu_op = 3'b010;
    v.pc_w = take; v.pc_src_s = s(PC_SRC_ALUOUT);
    return v;
  endfunction
  function automatic out_t v_jump();
    out_t v = '0;
    v.pc_w = 1'b1; v.pc_src_s = s(PC_SRC_JADDR);
    return v;
  endfunction
  function automatic out_t v_mds(input logic op);
    out_t v = '0;
    v.md_start = 1'b1; v.md_op = op;
    return v;
  endfunction
  function automatic out_t v_hilo();
    out_t v = '0;
    v.hilo_w = 1'b1;
    return v;
  endfunction
  function automatic out_t v_exc();
    out_t v = '0;
    v.epc_w = 1'b1; v.alu_a_s = s(ALU_A_PC); v.alu_b_s = s(ALU_B_FOUR); v.alu_op = 3'b010;
    return v;
  endfunction
  function automatic out_t v_excld(input int vec, input bit fin);
    out_t v = '0;
    v.mem_addr_s = s(vec);
    if (fin) begin v.pc_w = 1'b1; v.pc_src_s = s(PC_SRC_MEMBYTE); end
    return v;
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs, advance.
  task automatic cyc(input out_t e, input string nm, input logic rst_n,
                     input logic ov, input logic zr, input logic mdd, input logic dz);
    reset = rst_n; bus.overflow = ov; bus.zero = zr; bus.md_done = mdd; bus.div_zero = dz;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic exc(input int vec, input string nm);
    cyc(v_exc(), {"exc_", nm}, 1'b1, rb(), rb(), rb(), rb());
    for (int unsigned i = 0; i < W; i++)
      cyc(v_excld(vec, i == W - 1), {"exc_ld_", nm}, 1'b1, rb(), rb(), rb(), rb());
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op; bus.funct = fn;
    for (int unsigned i = 0; i < W; i++)
      cyc(v_fetch(i == W - 1), "fetch", 1'b1, rb(), rb(), rb(), rb());
    cyc(v_decode(), "decode", 1'b1, rb(), rb(), rb(), rb());
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input bit ovf,
                       input bit zr, input int unsigned md_delay, input bit dz);
    bit alu_r, md;
    alu_r = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
    md    = (op == 6'h00) && (fn == 6'h18 || fn == 6'h1A);
    fetch_decode(op, fn);
    if (alu_r) begin
      cyc(v_calc(ALU_B_B, (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011),
          "exec_r", 1'b1, ovf, rb(), rb(), rb());
      if (ovf && fn != 6'h24) exc(MEM_ADDR_VEC_OVF, "ovf");
      else cyc(v_wb(REG_DST_RD, WB_ALUOUT), "wb_r", 1'b1, rb(), rb(), rb(), rb());
    end else if (md) begin
      cyc(v_mds(fn[1]), "md_start", 1'b1, rb(), rb(), rb(), rb());
      for (int unsigned i = 1; i < md_delay; i++)
        cyc('0, "md_wait", 1'b1, rb(), rb(), 1'b0, rb());
      cyc('0, "md_wait_done", 1'b1, rb(), rb(), 1'b1, dz);
      if (fn == 6'h1A && dz) exc(MEM_ADDR_VEC_DIV, "div");
      else cyc(v_hilo(), "md_wb", 1'b1, rb(), rb(), rb(), rb());
    end else if (op == 6'h08) begin
      cyc(v_calc(ALU_B_SEXT, 3'b001), "exec_i", 1'b1, ovf, rb(), rb(), rb());
      if (ovf) exc(MEM_ADDR_VEC_OVF, "ovf");
      else cyc(v_wb(REG_DST_RT, WB_ALUOUT), "wb_i", 1'b1, rb(), rb(), rb(), rb());
    end else if (op == 6'h23 || op == 6'h2B) begin
      cyc(v_calc(ALU_B_SEXT, 3'b001), "addr", 1'b1, rb(), rb(), rb(), rb());
      if (op == 6'h23) begin
        for (int unsigned i = 0; i < W; i++)
          cyc(v_mem(1'b0), "lw_mem", 1'b1, rb(), rb(), rb(), rb());
        cyc(v_wb(REG_DST_RT, WB_MDR), "lw_wb", 1'b1, rb(), rb(), rb(), rb());
      end else begin
        cyc(v_mem(1'b1), "sw_mem", 1'b1, rb(), rb(), rb(), rb());
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      cyc(v_branch(zr ^ (op == 6'h05)), "branch", 1'b1, rb(), zr, rb(), rb());
    end else if (op == 6'h02) begin
      cyc(v_jump(), "jump", 1'b1, rb(), rb(), rb(), rb());
    end else begin
      exc(MEM_ADDR_VEC_OPC, "opc");
    end
  endtask

  initial begin : monitor
    out_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL %s @%0t state=%0d: got %h expected %h", n, $time, state_dbg, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [5:0] op, fn;
    int unsigned k;
    reset = 1'b0; bus.opcode = '0; bus.funct = '0;
    bus.overflow = 1'b0; bus.zero = 1'b0; bus.md_done = 1'b0; bus.div_zero = 1'b0;
    @(posedge clk); #1;
    cyc(v_rst(), "rst_hold", 1'b0, rb(), rb(), rb(), rb());
    cyc(v_rst(), "rst_release", 1'b1, rb(), rb(), rb(), rb());

    instr(6'h00, 6'h20, 1'b0, 1'b0, 1, 1'b0);   // add, no overflow
    instr(6'h00, 6'h20, 1'b1, 1'b0, 1, 1'b0);   // add, overflow
    instr(6'h00, 6'h1A, 1'b0, 1'b0, 33, 1'b1);  // div by zero after 33 cycles
    instr(6'h04, 6'h00, 1'b0, 1'b1, 1, 1'b0);   // beq taken
    instr(6'h05, 6'h00, 1'b0, 1'b1, 1, 1'b0);   // bne not taken
    instr(6'h3F, 6'h00, 1'b0, 1'b0, 1, 1'b0);   // invalid opcode
    instr(6'h00, 6'h18, 1'b0, 1'b0, 1, 1'b1);   // mult, done on entry

    // reset in the middle of MD_WAIT, then a stray md_done
    fetch_decode(6'h00, 6'h1A);
    cyc(v_mds(1'b1), "md_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc('0, "md_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc('0, "md_wait_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(v_rst(), "rst_mid", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    instr(6'h2B, 6'h00, 1'b0, 1'b0, 1, 1'b0);

    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 12);
      fn = 6'h00;
      case (k)
        0: begin op = 6'h00; fn = 6'h20; end
        1: begin op = 6'h00; fn = 6'h22; end
        2: begin op = 6'h00; fn = 6'h24; end
        3: op = 6'h08;
        4: op = 6'h23;
        5: op = 6'h2B;
        6: op = 6'h04;
        7: op = 6'h05;
        8: op = 6'h02;
        9: begin op = 6'h00; fn = 6'h18; end
        10: begin op = 6'h00; fn = 6'h1A; end
        11: begin
          do op = 6'($urandom_range(0, 63));
          while (op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h05 ||
                 op == 6'h08 || op == 6'h23 || op == 6'h2B);
        end
        default: begin
          op = 6'h00;
          do fn = 6'($urandom_range(0, 63));
          while (fn == 6'h18 || fn == 6'h1A || fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
        end
      endcase
      instr(op, fn, ($urandom_range(0, 2) == 0), rb(), $urandom_range(1, 6), rb());
    end

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
